csr_access_arbiter: RTL

//  Shares the single csr execution unit (the csr -> csr_regfile access path) between two requesters:

---
 rtl/csr_access_arbiter_if.sv | 54 +++++
 rtl/csr_access_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/csr_access_arbiter_if.sv
// csr_access_arbiter_if: requester-side and csr-unit-side signals of the CSR access arbiter. Rev 1.0
`default_nettype none

interface csr_access_arbiter_if #(
  parameter int XLEN                  = 64,
  parameter int CSR_ADDR_LEN          = 12,
  parameter int IMM_LEN               = 5,
  parameter int EXCEPTION_CAUSE_WIDTH = 5
);
  logic [1:0]                       req_valid_i;
  logic [1:0]                       req_ready_o;
  logic [2*3-1:0]                   req_func3_i;
  logic [2*XLEN-1:0]                req_rs1_data_i;
  logic [2*IMM_LEN-1:0]             req_imm_i;
  logic [2*CSR_ADDR_LEN-1:0]        req_csr_addr_i;
  logic [1:0]                       req_do_read_i;
  logic [1:0]                       req_do_write_i;
  logic                             flush_i;
  logic [1:0]                       resp_valid_o;
  logic [XLEN-1:0]                  resp_data_o;
  logic                             resp_exception_o;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] resp_ecause_o;
  logic                             csr_req_valid_o;
  logic [2:0]                       csr_func3_o;
  logic [XLEN-1:0]                  csr_rs1_data_o;
  logic [IMM_LEN-1:0]               csr_imm_o;
  logic [CSR_ADDR_LEN-1:0]          csr_addr_o;
  logic                             csr_do_read_o;
  logic                             csr_do_write_o;
  logic                             csr_resp_valid_i;
  logic [XLEN-1:0]                  csr_wrb_data_i;
  logic                             csr_exception_i;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] csr_ecause_i;

  modport slave (
    input  req_valid_i, req_func3_i, req_rs1_data_i, req_imm_i, req_csr_addr_i,
           req_do_read_i, req_do_write_i, flush_i,
           csr_resp_valid_i, csr_wrb_data_i, csr_exception_i, csr_ecause_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_exception_o, resp_ecause_o,
           csr_req_valid_o, csr_func3_o, csr_rs1_data_o, csr_imm_o, csr_addr_o,
           csr_do_read_o, csr_do_write_o
  );

  modport master (
    output req_valid_i, req_func3_i, req_rs1_data_i, req_imm_i, req_csr_addr_i,
           req_do_read_i, req_do_write_i, flush_i,
           csr_resp_valid_i, csr_wrb_data_i, csr_exception_i, csr_ecause_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_exception_o, resp_ecause_o,
           csr_req_valid_o, csr_func3_o, csr_rs1_data_o, csr_imm_o, csr_addr_o,
           csr_do_read_o, csr_do_write_o
  );
endinterface

`default_nettype wire

// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: round-robin sharing of the single CSR execution unit between two requesters,
// one transaction outstanding, with timeout retire and flush-kill of requester 0. Rev 1.0
`default_nettype none

module csr_access_arbiter #(
  parameter int XLEN                  = 64,
  parameter int CSR_ADDR_LEN          = 12,
  parameter int IMM_LEN               = 5,
  parameter int EXCEPTION_CAUSE_WIDTH = 5,
  parameter int TIMEOUT_CYCLES        = 16,
  parameter int TIMEOUT_ECAUSE        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  csr_access_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [EXCEPTION_CAUSE_WIDTH-1:0] C_TO_ECAUSE = EXCEPTION_CAUSE_WIDTH'(TIMEOUT_ECAUSE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                             r_owner;
  logic                             r_last_grant;
  logic                             r_kill;
  logic [CNT_W-1:0]                 r_cnt;

  logic [2:0]                       r_func3;
  logic [XLEN-1:0]                  r_rs1_data;
  logic [IMM_LEN-1:0]               r_imm;
  logic [CSR_ADDR_LEN-1:0]          r_addr;
  logic                             r_do_read;
  logic                             r_do_write;

  logic [XLEN-1:0]                  r_resp_data;
  logic                             r_resp_exc;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] r_resp_ecause;

  logic [1:0] w_eligible;
  logic       w_grant;
  logic       w_accept;
  logic       w_capture;
  logic       w_timeout;

  // Flush only masks the pipeline requester; the config master is never flushed.
  assign w_eligible = bus.req_valid_i & {1'b1, ~bus.flush_i};
  assign w_grant    = (w_eligible == 2'b11) ? ~r_last_grant : w_eligible[1];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_eligible) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.csr_resp_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real response arriving on the timeout cycle takes priority.
        if (bus.csr_resp_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == C_CNT_MAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_func3      <= '0;
      r_rs1_data   <= '0;
      r_imm        <= '0;
      r_addr       <= '0;
      r_do_read    <= 1'b0;
      r_do_write   <= 1'b0;
    end else if (w_accept) begin
      r_owner      <= w_grant;
      r_last_grant <= w_grant;
      r_func3      <= w_grant ? bus.req_func3_i[5:3] : bus.req_func3_i[2:0];
      r_rs1_data   <= w_grant ? bus.req_rs1_data_i[2*XLEN-1:XLEN]
                              : bus.req_rs1_data_i[XLEN-1:0];
      r_imm        <= w_grant ? bus.req_imm_i[2*IMM_LEN-1:IMM_LEN]
                              : bus.req_imm_i[IMM_LEN-1:0];
      r_addr       <= w_grant ? bus.req_csr_addr_i[2*CSR_ADDR_LEN-1:CSR_ADDR_LEN]
                              : bus.req_csr_addr_i[CSR_ADDR_LEN-1:0];
      r_do_read    <= bus.req_do_read_i[w_grant];
      r_do_write   <= bus.req_do_write_i[w_grant];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kill <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_kill <= 1'b0;
      end else if ((r_state == S_ISSUE || r_state == S_WAIT) && !r_owner && bus.flush_i) begin
        r_kill <= 1'b1;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_data   <= '0;
      r_resp_exc    <= 1'b0;
      r_resp_ecause <= '0;
    end else if (w_capture) begin
      r_resp_data   <= bus.csr_wrb_data_i;
      r_resp_exc    <= bus.csr_exception_i;
      r_resp_ecause <= bus.csr_ecause_i;
    end else if (w_timeout) begin
      r_resp_data   <= '0;
      r_resp_exc    <= 1'b1;
      r_resp_ecause <= C_TO_ECAUSE;
    end
  end

  // Ready is combinational in IDLE, so hold it low while reset is asserted.
  assign bus.req_ready_o      = (w_accept && rst_n) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.csr_req_valid_o  = (r_state == S_ISSUE);
  assign bus.resp_valid_o     = (r_state == S_RESP) ? (r_owner ? 2'b10 : {1'b0, ~r_kill}) : 2'b00;
  assign bus.resp_data_o      = r_resp_data;
  assign bus.resp_exception_o = r_resp_exc;
  assign bus.resp_ecause_o    = r_resp_ecause;
  assign bus.csr_func3_o      = r_func3;
  assign bus.csr_rs1_data_o   = r_rs1_data;
  assign bus.csr_imm_o        = r_imm;
  assign bus.csr_addr_o       = r_addr;
  assign bus.csr_do_read_o    = r_do_read;
  assign bus.csr_do_write_o   = r_do_write;

endmodule

`default_nettype wire
